rr_weighted_scheduler: RTL and testbench
========================================

# rr_weighted_scheduler

Weighted round-robin scheduler that shares one downstream resource (bus port, memory bank, shared datapath) among N requesters. It grants one requester at a time, holds the grant for up to that requester's programmed number of transactions (its weight), then rotates priority to the next index. It sits between the requester blocks and the shared resource; `done_i` comes from the resource and signals each completed transaction. Per-requester weights are programmed at run time through a small configuration write port.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `WEIGHT_W`, default 4: width of each weight and of the credit counter.
- `ID_W`, default `$clog2(N)`: width of `gnt_id_o`.

- `clk`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `req_i`, input, N: level request, one bit per requester. A requester holds its bit high while it wants or owns the resource.
- `done_i`, input, 1: one-cycle pulse from the resource marking one completed transaction for the current owner.
- `cfg_we_i`, input, 1: weight write strobe.
- `cfg_idx_i`, input, ID_W: index of the weight to write.
- `cfg_weight_i`, input, WEIGHT_W: new weight value.
- `gnt_o`, output, N: one-hot or all-zero grant. Registered.
- `gnt_id_o`, output, ID_W: binary index of the current owner. Valid only while `gnt_valid_o` is 1; 0 otherwise.
- `gnt_valid_o`, output, 1: 1 when `gnt_o` is non-zero.

## Operation
**Reset values:**
- `gnt_o` = 0, `gnt_id_o` = 0, `gnt_valid_o` = 0.
- State = IDLE, priority pointer `ptr` = 0, credit = 0.
- Every weight register = 1.

**Weight registers:**
- A write with `cfg_we_i` = 1 updates `weight[cfg_idx_i]` at the clock edge. A write with `cfg_idx_i` ≥ N is ignored.
- A weight of 0 is treated as 1.
- A new weight takes effect at that requester's next grant. It never changes the credit of a grant already in progress.

**State IDLE:**
- `gnt_o` = 0.
- If `req_i` ≠ 0, select the first set bit found by searching upward from `ptr`, wrapping from N-1 to 0.
- Load `credit` = effective weight of the selected requester, load `gnt_o` and `gnt_id_o`, and go to GRANT.
- If `req_i` = 0, stay in IDLE.

**State GRANT** (owner k). Release the grant when either condition holds:
- (a) `req_i[k]` = 0, or
- (b) `done_i` = 1 and `credit` = 1.

On release:
- `gnt_o` goes to 0 at that edge.
- `ptr` is set to (k+1) mod N.
- State returns to IDLE.

Otherwise, when `done_i` = 1, decrement `credit` and keep the grant.

**Ignored and coincident inputs:**
- `done_i` in IDLE is ignored.
- Requests from non-owners during GRANT have no effect; there is no pre-emption.
- If (a) and (b) are true in the same cycle, perform a single release with a single `ptr` update.

**Invariants:**
- At most one bit of `gnt_o` is set.
- `gnt_o[k]` is never set while `req_i[k]` was 0 at the granting edge.

## Timing
- **Grant latency:** a request seen in IDLE at edge t produces the grant at edge t. Registered outputs are visible from t onward, one cycle after `req_i` is presented.
- **Handover bubble:** on release at edge t, `gnt_o` = 0 for the cycle after t. The next grant appears at edge t+1. Every grant is therefore separated by exactly one idle cycle.
- **Maximum occupancy:** one grant lasts at most `weight` `done_i` pulses. There is no timeout; a stuck owner holds the resource until it drops its request.
- **Reset mid-grant:** `gnt_o` clears immediately and asynchronously. After release, `ptr` = 0 and all weights = 1; programmed weights are lost.
- **Configuration coincident with a grant:**
  - A `cfg_we_i` write to the requester being granted on the same edge is not used for that grant; the old weight loads into `credit`.
  - The new value applies from the following grant.

## Test plan
- **Reset and idle:** hold `reset` = 0 with `req_i` = 4'hF → `gnt_o` = 0. Release reset with `req_i` = 4'hF → `gnt_o` = 0001 one cycle later, `gnt_id_o` = 0.
- **Rotation with default weight 1:** `req_i` = 4'hF, pulse `done_i` once per grant → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001. `gnt_o` is never multi-hot.
- **Weighted burst:** write `weight[2]` = 3, `req_i` = 4'b0100 → `gnt_o` = 0100 is held through 2 `done_i` pulses and drops on the 3rd. The next grant to requester 2 again allows 3 transactions.
- **Early release and wrap-around:**
  - Requester 3 is granted with weight 2, then `req_i[3]` falls before any `done_i` → `gnt_o` = 0 next edge and `ptr` wraps to 0.
  - With `req_i` = 4'b1001 afterwards → requester 0 is granted next.
- **Weight-0 and invalid config:**
  - Write `weight[1]` = 0 → requester 1 releases after 1 `done_i`.
  - Write with `cfg_idx_i` = 5 when N = 4 → no weight changes.
- **Asynchronous reset mid-grant:** assert `reset` = 0 mid-cycle while `gnt_o` = 0100 with credit remaining → `gnt_o` = 0 immediately. After release with `req_i` = 4'hF → requester 0 is granted first, with weight 1.

Source files
------------

// File: rtl/rr_weighted_scheduler.sv
// rtl/rr_weighted_scheduler.sv - weighted round-robin grant of one shared resource among N requesters
module rr_weighted_scheduler #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req_i,
  input  logic                done_i,
  input  logic                cfg_we_i,
  input  logic [ID_W-1:0]     cfg_idx_i,
  input  logic [WEIGHT_W-1:0] cfg_weight_i,
  output logic [N-1:0]        gnt_o,
  output logic [ID_W-1:0]     gnt_id_o,
  output logic                gnt_valid_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [WEIGHT_W-1:0] credit_q;
  logic [WEIGHT_W-1:0] weight_q [N];
  logic [N-1:0]        gnt_q;
  logic [ID_W-1:0]     gnt_id_q;

  logic [2*N-1:0]      req_dbl;
  logic [N-1:0]        req_rot;
  logic [ID_W-1:0]     sel_off;
  logic [ID_W:0]       sel_sum;
  logic [ID_W-1:0]     sel_idx;
  logic [WEIGHT_W-1:0] sel_weight;
  logic                owner_req;
  logic                last_done;
  logic [ID_W-1:0]     ptr_next;

  // Rotate requests so bit 0 is the current priority holder, then pick the lowest set bit.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_q;
    req_rot = req_dbl[N-1:0];
    sel_off = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req_rot[off]) sel_off = ID_W'(off);
    end
    sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
    if (sel_sum >= (ID_W+1)'(N)) sel_sum = sel_sum - (ID_W+1)'(N);
    sel_idx    = sel_sum[ID_W-1:0];
    sel_weight = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == ID_W'(i)) sel_weight = weight_q[i];
    end
    if (sel_weight == '0) sel_weight = WEIGHT_W'(1);
  end

  assign owner_req = |(req_i & gnt_q);
  assign last_done = done_i && (credit_q == WEIGHT_W'(1));
  assign ptr_next  = (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + ID_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q  <= GRANT;
            gnt_q    <= N'(1) << sel_idx;
            gnt_id_q <= sel_idx;
            credit_q <= sel_weight;
          end
        end
        GRANT: begin
          if (!owner_req || last_done) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= ptr_next;
          end else if (done_i) begin
            credit_q <= credit_q - WEIGHT_W'(1);
          end
        end
      endcase
    end
  end

  // Written weights are only sampled when a grant starts, so an in-flight credit is never disturbed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) weight_q[i] <= WEIGHT_W'(1);
    end else if (cfg_we_i) begin
      for (int i = 0; i < N; i++) begin
        if (cfg_idx_i == ID_W'(i)) weight_q[i] <= cfg_weight_i;
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = |gnt_q;

endmodule

// File: tb/tb_rr_weighted_scheduler.sv
// tb/tb_rr_weighted_scheduler.sv - directed bench with a behavioural reference for rr_weighted_scheduler
module tb_rr_weighted_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [3:0] cfg_w;
  logic [3:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rr_weighted_scheduler #(.N(4), .WEIGHT_W(4), .ID_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req),
    .done_i       (done),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_weight_i (cfg_w),
    .gnt_o        (gnt),
    .gnt_id_o     (gnt_id),
    .gnt_valid_o  (gnt_valid)
  );

  // Reference: owner is -1 when idle, otherwise the index currently holding the resource.
  int m_owner;
  int m_ptr;
  int m_credit;
  int m_w [4];
  int m_next_w [4];
  int m_cand;
  bit m_found;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_credit = 0;
      for (int i = 0; i < 4; i++) m_w[i] = 1;
    end else begin
      m_next_w = m_w;
      if (cfg_we && cfg_idx < 4) m_next_w[cfg_idx] = int'(cfg_w);
      if (m_owner < 0) begin
        m_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          m_cand = (m_ptr + k) % 4;
          if (!m_found && req[m_cand]) begin
            m_found  = 1'b1;
            m_owner  = m_cand;
            m_credit = (m_w[m_cand] == 0) ? 1 : m_w[m_cand];
          end
        end
      end else if (!req[m_owner] || (done && m_credit == 1)) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (done) begin
        m_credit = m_credit - 1;
      end
      m_w = m_next_w;
    end
  end

  logic [7:0] exp_pack;
  logic [7:0] act_pack;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_pack = (m_owner < 0) ? 8'h00 : {1'b1, 3'(m_owner), 4'(1 << m_owner)};
      act_pack = {gnt_valid, gnt_id, gnt};
      vectors++;
      if (act_pack !== exp_pack) begin
        miscompares++;
        $display("FAIL model_cycle t=%0t valid/id/gnt got %b/%0d/%b want %b/%0d/%b",
                 $time, act_pack[7], act_pack[6:4], act_pack[3:0],
                 exp_pack[7], exp_pack[6:4], exp_pack[3:0]);
      end
      vectors++;
      if ($countones(gnt) > 1) begin
        miscompares++;
        $display("FAIL onehot t=%0t gnt got %b want at most one bit", $time, gnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string nm, input logic [3:0] e);
    logic [2:0] eid;
    eid = '0;
    for (int i = 0; i < 4; i++) if (e[i]) eid = 3'(i);
    vectors++;
    if ({gnt_valid, gnt_id, gnt} !== {|e, eid, e}) begin
      miscompares++;
      $display("FAIL %s t=%0t valid/id/gnt got %b/%0d/%b want %b/%0d/%b",
               nm, $time, gnt_valid, gnt_id, gnt, |e, eid, e);
    end
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [3:0] w);
    cfg_we = 1'b1; cfg_idx = idx; cfg_w = w;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = 4'hF; done = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_w = '0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    expect_gnt("reset_hold", 4'b0000);
    reset = 1'b1;
    tick();
    expect_gnt("first_grant", 4'b0001);

    for (int k = 0; k < 4; k++) begin
      done = 1'b1; tick(); expect_gnt("rot_release", 4'b0000);
      done = 1'b0; tick(); expect_gnt("rot_grant", 4'(1 << ((k + 1) % 4)));
    end
    req = 4'b0000; tick(); expect_gnt("drop_release", 4'b0000);

    cfg_write(3'd2, 4'd3);
    req = 4'b0100; tick(); expect_gnt("burst_grant", 4'b0100);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 2; j++) begin
        done = 1'b1; tick(); expect_gnt("burst_hold", 4'b0100);
      end
      done = 1'b1; tick(); expect_gnt("burst_end", 4'b0000);
      done = 1'b0;
      if (r == 0) begin
        tick(); expect_gnt("burst_regrant", 4'b0100);
      end
    end
    req = 4'b0000; tick();

    cfg_write(3'd3, 4'd2);
    req = 4'b1000; tick(); expect_gnt("w3_grant", 4'b1000);
    req = 4'b0000; tick(); expect_gnt("early_release", 4'b0000);
    req = 4'b1001; tick(); expect_gnt("wrap_grant", 4'b0001);
    done = 1'b1; tick(); expect_gnt("wrap_release", 4'b0000);
    done = 1'b0; tick(); expect_gnt("w3_regrant", 4'b1000);
    done = 1'b1; tick(); expect_gnt("w3_hold", 4'b1000);
    tick(); expect_gnt("w3_end", 4'b0000);
    done = 1'b0; req = 4'b0000; tick();

    cfg_write(3'd1, 4'd0);
    cfg_write(3'd5, 4'd7);
    req = 4'b0010; tick(); expect_gnt("w0_grant", 4'b0010);
    done = 1'b1; tick(); expect_gnt("w0_release", 4'b0000);
    done = 1'b0; req = 4'b0000; tick();

    req = 4'b0001; cfg_we = 1'b1; cfg_idx = 3'd0; cfg_w = 4'd2;
    tick(); expect_gnt("coinc_grant", 4'b0001);
    cfg_we = 1'b0;
    done = 1'b1; tick(); expect_gnt("coinc_old_weight", 4'b0000);
    done = 1'b0; tick(); expect_gnt("coinc_regrant", 4'b0001);
    done = 1'b1; tick(); expect_gnt("coinc_new_hold", 4'b0001);
    tick(); expect_gnt("coinc_new_end", 4'b0000);
    done = 1'b0; req = 4'b0000; tick();

    req = 4'b0100; tick(); expect_gnt("mid_grant", 4'b0100);
    done = 1'b1; tick(); expect_gnt("mid_hold", 4'b0100);
    done = 1'b0;
    #3 reset = 1'b0;
    #1 expect_gnt("async_clear", 4'b0000);
    tick();
    req = 4'hF; reset = 1'b1;
    tick(); expect_gnt("post_reset_grant", 4'b0001);
    done = 1'b1; tick(); expect_gnt("post_reset_w0", 4'b0000);
    done = 1'b0; tick(); expect_gnt("post_reset_g1", 4'b0010);
    done = 1'b1; tick(); expect_gnt("post_reset_w1", 4'b0000);
    done = 1'b0; tick(); expect_gnt("post_reset_g2", 4'b0100);
    done = 1'b1; tick(); expect_gnt("w2_restored", 4'b0000);
    done = 1'b0; req = 4'b0000; tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
